// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multicycle sequencer for the datapath. It steps each instruction through
//   FETCH/DECODE/EXEC/MEM/WB around variable-latency ihit/dhit handshakes.
//   It also tracks the LL/SC link, an optional memory-wait timeout and a
//   sticky halt.
//
// State table
//   state  | meaning
//   RESET  | post-reset idle; all outputs low; next edge goes to FETCH
//   FETCH  | iREN high until ihit; irWEN on the hit cycle
//   DECODE | IR fields decoded; HALT opcode diverts to HALT
//   EXEC   | ALU controls valid; branches/jumps update PC and finish here
//   MEM    | dREN/dWEN until dhit; SW finishes here, SC without link skips
//   WB     | register file write plus PC update
//   HALT   | cpu_halt high, no requests, left only through reset
//
// Ports
//   CLK, nRST          clock (rising edge), async active-low reset
//   imemload           instruction word from the icache
//   ihit, dhit         instruction / data request complete
//   zero               ALU zero flag, sampled in EXEC
//   link_inval         external invalidate of the LL link
//   iREN, dREN, dWEN   cache request lines
//   irWEN, pcWEN, WEN  IR latch, PC update and register file write strobes
//   datomic            marks an LL/SC data access
//   wsel               destination register
//   alusrc, wdatsel, aluop, pc_select   datapath mux / ALU controls
//   immediate          sign-extended immediate (zero-extended for ANDI/ORI/XORI)
//   lui_word           immediate placed in the upper half
//   sc_success         SC outcome, written as rt data in the SC write-back
//   mem_err            sticky; a fetch or data wait timed out
//   cpu_halt           sticky halt
module multicycle_control_unit #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] imemload,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  input  logic              link_inval,
  output logic              iREN,
  output logic              irWEN,
  output logic              pcWEN,
  output logic              dREN,
  output logic              dWEN,
  output logic              datomic,
  output logic              WEN,
  output logic [4:0]        wsel,
  output logic [1:0]        alusrc,
  output logic [2:0]        wdatsel,
  output logic [3:0]        aluop,
  output logic [1:0]        pc_select,
  output logic [WORD_W-1:0] immediate,
  output logic [WORD_W-1:0] lui_word,
  output logic              sc_success,
  output logic              mem_err,
  output logic              cpu_halt
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                         OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_LL   = 6'h30,
                         OP_SC    = 6'h38, OP_HALT = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_JR   = 6'h08, FN_ADD  = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2,
                         ALU_SUB = 4'd3, ALU_AND = 4'd4, ALU_OR  = 4'd5,
                         ALU_XOR = 4'd6, ALU_NOR = 4'd7, ALU_SLT = 4'd8,
                         ALU_SLTU = 4'd9;

  localparam logic [1:0] ALUSRC_REG = 2'd0, ALUSRC_IMM = 2'd1, ALUSRC_SHAMT = 2'd2;

  localparam logic [2:0] WDAT_ALU = 3'd0, WDAT_MEM = 3'd1, WDAT_PC4 = 3'd2,
                         WDAT_LUI = 3'd3, WDAT_SC  = 3'd4;

  localparam logic [1:0] PC_NEXT = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_JR = 2'd3;

  // Wait-counter value seen during the last permitted wait cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {RESET, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] ir;
  logic              link;
  logic              sc_flag;
  logic [TO_W-1:0]   wait_cnt;

  logic [5:0] opcode, funct;
  logic [4:0] rt, rd;
  logic       unused_rs;

  logic [3:0] dec_aluop;
  logic [1:0] dec_alusrc;
  logic [2:0] dec_wdatsel;
  logic [4:0] dec_wsel;
  logic       imm_zext;
  logic       is_lw, is_sw, is_ll, is_sc, is_beq, is_bne, is_j, is_jr, is_jal, is_halt;

  logic is_mem, sc_skip, waiting, wait_hit, to_expire, sc_done, dec_en;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign unused_rs = ^ir[25:21];

  always_comb begin
    dec_aluop   = ALU_ADD;
    dec_alusrc  = ALUSRC_IMM;
    dec_wdatsel = WDAT_ALU;
    dec_wsel    = rt;
    imm_zext    = 1'b0;
    is_lw = 1'b0; is_sw = 1'b0; is_ll = 1'b0; is_sc = 1'b0; is_beq = 1'b0;
    is_bne = 1'b0; is_j = 1'b0; is_jr = 1'b0; is_jal = 1'b0; is_halt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_alusrc = ALUSRC_REG;
        dec_wsel   = rd;
        case (funct)
          FN_SLL:          begin dec_aluop = ALU_SLL; dec_alusrc = ALUSRC_SHAMT; end
          FN_SRL:          begin dec_aluop = ALU_SRL; dec_alusrc = ALUSRC_SHAMT; end
          FN_SLLV:         dec_aluop = ALU_SLL;
          FN_SRLV:         dec_aluop = ALU_SRL;
          FN_JR:           is_jr = 1'b1;
          FN_ADD, FN_ADDU: dec_aluop = ALU_ADD;
          FN_SUB, FN_SUBU: dec_aluop = ALU_SUB;
          FN_AND:          dec_aluop = ALU_AND;
          FN_OR:           dec_aluop = ALU_OR;
          FN_XOR:          dec_aluop = ALU_XOR;
          FN_NOR:          dec_aluop = ALU_NOR;
          FN_SLT:          dec_aluop = ALU_SLT;
          FN_SLTU:         dec_aluop = ALU_SLTU;
          default:         dec_aluop = ALU_ADD;
        endcase
      end
      OP_J:     is_j = 1'b1;
      OP_JAL:   begin is_jal = 1'b1; dec_wsel = 5'd31; dec_wdatsel = WDAT_PC4; end
      OP_BEQ:   begin is_beq = 1'b1; dec_aluop = ALU_SUB; dec_alusrc = ALUSRC_REG; end
      OP_BNE:   begin is_bne = 1'b1; dec_aluop = ALU_SUB; dec_alusrc = ALUSRC_REG; end
      OP_ADDIU: dec_aluop = ALU_ADD;
      OP_SLTI:  dec_aluop = ALU_SLT;
      OP_SLTIU: dec_aluop = ALU_SLTU;
      OP_ANDI:  begin dec_aluop = ALU_AND; imm_zext = 1'b1; end
      OP_ORI:   begin dec_aluop = ALU_OR;  imm_zext = 1'b1; end
      OP_XORI:  begin dec_aluop = ALU_XOR; imm_zext = 1'b1; end
      OP_LUI:   dec_wdatsel = WDAT_LUI;
      OP_LW:    begin is_lw = 1'b1; dec_wdatsel = WDAT_MEM; end
      OP_SW:    is_sw = 1'b1;
      OP_LL:    begin is_ll = 1'b1; dec_wdatsel = WDAT_MEM; end
      OP_SC:    begin is_sc = 1'b1; dec_wdatsel = WDAT_SC; end
      OP_HALT:  is_halt = 1'b1;
      default:  dec_aluop = ALU_ADD;
    endcase
  end

  assign is_mem   = is_lw | is_sw | is_ll | is_sc;
  // SC that lost its link at MEM entry issues no request at all.
  assign sc_skip  = is_sc & ~sc_flag;
  assign waiting  = (state == FETCH) | ((state == MEM) & ~sc_skip);
  assign wait_hit = (state == FETCH) ? ihit : dhit;
  // Expires on the TIMEOUT-th consecutive miss; a hit in that cycle still wins.
  assign to_expire = (TIMEOUT > 0) & waiting & ~wait_hit & (wait_cnt == TO_LAST);

  always_comb begin
    state_next = state;
    iREN       = 1'b0;
    irWEN      = 1'b0;
    pcWEN      = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    datomic    = 1'b0;
    WEN        = 1'b0;
    pc_select  = PC_NEXT;
    case (state)
      RESET: state_next = FETCH;
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          irWEN      = 1'b1;
          state_next = DECODE;
        end else if (to_expire) begin
          state_next = HALT;
        end
      end
      DECODE: state_next = is_halt ? HALT : EXEC;
      EXEC: begin
        if (is_beq | is_bne | is_j | is_jr) begin
          pcWEN = 1'b1;
          if ((is_beq & zero) | (is_bne & ~zero)) pc_select = PC_BRANCH;
          else if (is_j)                           pc_select = PC_JUMP;
          else if (is_jr)                          pc_select = PC_JR;
          state_next = FETCH;
        end else if (is_mem) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        datomic = is_ll | is_sc;
        if (sc_skip) begin
          state_next = WB;
        end else begin
          dREN = is_lw | is_ll;
          dWEN = is_sw | is_sc;
          if (dhit) begin
            if (is_sw) begin
              pcWEN      = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = WB;
            end
          end else if (to_expire) begin
            state_next = HALT;
          end
        end
      end
      WB: begin
        WEN        = 1'b1;
        pcWEN      = 1'b1;
        pc_select  = is_jal ? PC_JUMP : PC_NEXT;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = RESET;
    endcase
  end

  assign sc_done = (state == MEM) & is_sc & (state_next != MEM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RESET;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (irWEN) ir <= imemload;
    end
  end

  // An LL completing in the same cycle as an invalidate keeps the link:
  // the invalidate is ordered before the load.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link    <= 1'b0;
      sc_flag <= 1'b0;
    end else begin
      if ((state == MEM) & is_ll & dhit) link <= 1'b1;
      else if (link_inval | sc_done)     link <= 1'b0;
      if ((state == EXEC) & (state_next == MEM)) sc_flag <= link & ~link_inval;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if ((state_next != state) | wait_hit)           wait_cnt <= '0;
      else if ((TIMEOUT > 0) & waiting)               wait_cnt <= wait_cnt + TO_W'(1);
      if (to_expire) mem_err <= 1'b1;
    end
  end

  // Decoded controls are forced low in RESET so every output starts at 0.
  assign dec_en     = (state != RESET);
  assign wsel       = dec_en ? dec_wsel    : 5'd0;
  assign alusrc     = dec_en ? dec_alusrc  : ALUSRC_REG;
  assign wdatsel    = dec_en ? dec_wdatsel : WDAT_ALU;
  assign aluop      = dec_en ? dec_aluop   : ALU_SLL;
  assign immediate  = !dec_en  ? '0 :
                      imm_zext ? {{(WORD_W-16){1'b0}}, ir[15:0]} :
                                 {{(WORD_W-16){ir[15]}}, ir[15:0]};
  assign lui_word   = dec_en ? {ir[15:0], {(WORD_W-16){1'b0}}} : '0;
  assign sc_success = sc_flag & is_sc & ((state == MEM) | (state == WB));
  assign cpu_halt   = (state == HALT);

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_LL   = 32'hC0850000;
  localparam logic [31:0] I_SC   = 32'hE0850000;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_HALT = 32'hFFFFFFFF;

  localparam int ALU_ADD = 2, ALU_SUB = 3;
  localparam int SRC_REG = 0, SRC_IMM = 1;
  localparam int WD_ALU = 0, WD_MEM = 1, WD_SC = 4;
  localparam int PC_NEXT = 0, PC_BRANCH = 1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] imemload;
  logic        ihit, dhit, zero, link_inval;
  logic        iREN, irWEN, pcWEN, dREN, dWEN, datomic, WEN;
  logic [4:0]  wsel;
  logic [1:0]  alusrc;
  logic [2:0]  wdatsel;
  logic [3:0]  aluop;
  logic [1:0]  pc_select;
  logic [31:0] immediate, lui_word;
  logic        sc_success, mem_err, cpu_halt;

  int n_checks = 0;
  int n_errors = 0;

  int   o_cycles, o_irwen, o_irwen_cyc, o_iren, o_dren, o_dwen, o_atomic;
  int   o_wen, o_wen_cyc, o_wsel, o_pcsel, o_imm, o_aluop, o_alusrc, o_wdatsel;
  logic o_sc, o_done;

  multicycle_control_unit #(.WORD_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .imemload(imemload), .ihit(ihit), .dhit(dhit),
    .zero(zero), .link_inval(link_inval), .iREN(iREN), .irWEN(irWEN),
    .pcWEN(pcWEN), .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .WEN(WEN),
    .wsel(wsel), .alusrc(alusrc), .wdatsel(wdatsel), .aluop(aluop),
    .pc_select(pc_select), .immediate(immediate), .lui_word(lui_word),
    .sc_success(sc_success), .mem_err(mem_err), .cpu_halt(cpu_halt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one instruction starting in its first FETCH cycle; ends on the pcWEN cycle.
  task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                           input logic z, input int inval_cyc);
    int dreqs;
    dreqs = 0;
    o_cycles = 0; o_irwen = 0; o_irwen_cyc = -1; o_iren = 0; o_dren = 0; o_dwen = 0;
    o_atomic = 0; o_wen = 0; o_wen_cyc = -1; o_wsel = -1; o_pcsel = -1; o_imm = 0;
    o_aluop = -1; o_alusrc = -1; o_wdatsel = -1; o_sc = 1'b0; o_done = 1'b0;
    for (int c = 0; c < 40 && !o_done; c++) begin
      imemload   = instr;
      zero       = z;
      ihit       = (c == iwait);
      dhit       = (dreqs == dwait);
      link_inval = (c == inval_cyc);
      #1;
      if (irWEN) begin o_irwen++; o_irwen_cyc = c; end
      if (iREN) o_iren++;
      if (dREN) o_dren++;
      if (dWEN) o_dwen++;
      if (dREN || dWEN) dreqs++;
      if (datomic) o_atomic++;
      if (WEN) begin
        o_wen++; o_wen_cyc = c; o_wsel = wsel; o_sc = sc_success; o_imm = immediate;
        o_aluop = aluop; o_alusrc = alusrc; o_wdatsel = wdatsel;
      end
      if (pcWEN) begin o_pcsel = pc_select; o_cycles = c + 1; o_done = 1'b1; end
      tick();
    end
    ihit = 1'b0; dhit = 1'b0; link_inval = 1'b0;
    check("instr_done", o_done, 1);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check("rst_async_halt", cpu_halt, 0);
    check("rst_async_err", mem_err, 0);
    tick();
    nRST = 1'b1;
    #1;
    check("rst_release_iren", iREN, 0);
    tick();
  endtask

  initial begin
    nRST = 1'b0; imemload = '0; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; link_inval = 1'b0;
    tick(); tick();
    check("rst_strobes", {iREN, irWEN, pcWEN, dREN, dWEN, datomic, WEN, sc_success, mem_err, cpu_halt}, 0);
    check("rst_ctrl", {wsel, alusrc, wdatsel, aluop, pc_select}, 0);
    check("rst_imm", immediate | lui_word, 0);
    nRST = 1'b1;
    #1;
    check("reset_hold_iren", iREN, 0);
    tick();

    // ADDU with two fetch wait cycles
    run_instr(I_ADDU, 2, 0, 1'b0, -1);
    check("addu_iren", o_iren, 3);
    check("addu_irwen_n", o_irwen, 1);
    check("addu_irwen_cyc", o_irwen_cyc, 2);
    check("addu_wen_cyc", o_wen_cyc, 5);
    check("addu_wsel", o_wsel, 3);
    check("addu_aluop", o_aluop, ALU_ADD);
    check("addu_alusrc", o_alusrc, SRC_REG);
    check("addu_cycles", o_cycles, 6);

    // LW with one data wait cycle
    run_instr(I_LW, 0, 1, 1'b0, -1);
    check("lw_dren", o_dren, 2);
    check("lw_imm", o_imm, 32'h4);
    check("lw_wsel", o_wsel, 2);
    check("lw_wen_n", o_wen, 1);
    check("lw_wdatsel", o_wdatsel, WD_MEM);
    check("lw_alusrc", o_alusrc, SRC_IMM);
    check("lw_cycles", o_cycles, 6);

    // SW: finishes in MEM
    run_instr(I_SW, 0, 0, 1'b0, -1);
    check("sw_dwen", o_dwen, 1);
    check("sw_wen", o_wen, 0);
    check("sw_cycles", o_cycles, 4);

    // LL/SC with link intact
    run_instr(I_LL, 0, 0, 1'b0, -1);
    check("ll_atomic", o_atomic, 1);
    check("ll_dren", o_dren, 1);
    check("ll_cycles", o_cycles, 5);
    run_instr(I_SC, 0, 0, 1'b0, -1);
    check("sc_atomic", o_atomic, 1);
    check("sc_dwen", o_dwen, 1);
    check("sc_success", o_sc, 1);
    check("sc_wdatsel", o_wdatsel, WD_SC);
    check("sc_cycles", o_cycles, 5);

    // LL, then invalidate during the SC fetch
    run_instr(I_LL, 0, 0, 1'b0, -1);
    run_instr(I_SC, 0, 0, 1'b0, 0);
    check("scf_dwen", o_dwen, 0);
    check("scf_success", o_sc, 0);
    check("scf_wen", o_wen, 1);
    check("scf_wsel", o_wsel, 5);
    check("scf_atomic", o_atomic, 1);
    check("scf_cycles", o_cycles, 5);

    // Invalidate coinciding with the LL dhit: the link still gets set
    run_instr(I_LL, 0, 0, 1'b0, 3);
    run_instr(I_SC, 0, 0, 1'b0, -1);
    check("scset_dwen", o_dwen, 1);
    check("scset_success", o_sc, 1);

    // BEQ taken / not taken
    run_instr(I_BEQ, 0, 0, 1'b1, -1);
    check("beq_t_pcsel", o_pcsel, PC_BRANCH);
    check("beq_t_cycles", o_cycles, 3);
    check("beq_t_wen", o_wen, 0);
    run_instr(I_BEQ, 0, 0, 1'b0, -1);
    check("beq_nt_pcsel", o_pcsel, PC_NEXT);
    check("beq_nt_cycles", o_cycles, 3);
    check("beq_nt_wen", o_wen, 0);

    // Fetch timeout: four missed cycles, then HALT with mem_err
    imemload = I_ADDU;
    for (int c = 0; c < 4; c++) begin
      ihit = 1'b0;
      #1;
      check("to_iren", iREN, 1);
      check("to_err_early", mem_err, 0);
      tick();
    end
    #1;
    check("to_mem_err", mem_err, 1);
    check("to_halt", cpu_halt, 1);
    check("to_iren_off", iREN, 0);
    tick();
    ihit = 1'b1;
    #1;
    check("to_halt_sticky", {cpu_halt, iREN}, 2'b10);
    ihit = 1'b0;
    do_reset();

    // Hit on the last permitted wait cycle is honoured
    run_instr(I_ADDU, 3, 0, 1'b0, -1);
    check("to_edge_cycles", o_cycles, 7);
    check("to_edge_wsel", o_wsel, 3);
    check("to_edge_err", mem_err, 0);

    // HALT opcode
    imemload = I_HALT;
    ihit = 1'b1;
    #1;
    check("halt_irwen", irWEN, 1);
    tick();
    ihit = 1'b0;
    #1;
    check("halt_decode", cpu_halt, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      ihit = 1'b1;
      #1;
      check("halt_state", {cpu_halt, iREN, dREN, dWEN, WEN, pcWEN}, 6'b100000);
      tick();
    end
    nRST = 1'b0;
    #1;
    check("halt_rst_clear", cpu_halt, 0);
    check("halt_rst_iren", iREN, 0);
    ihit = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing control for the multicycle datapath. It replaces the single-cycle decoder's purely combinational outputs with a state machine that sequences FETCH/DECODE/EXEC/MEM/WB around variable-latency ihit/dhit handshakes. It supports LL/SC through an internal link flag, a configurable memory-wait timeout and a sticky halt. It sits between the instruction register/PC and the datapath muxes, register file and cache request lines.

## Interface

**Parameters**

- WORD_W, 32, instruction/immediate width.
- TIMEOUT, 0, max cycles waiting on ihit/dhit; 0 disables the timeout.
- TO_W, 8, width of the wait counter; TIMEOUT < 2^TO_W.

**Ports**

- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemload  in  WORD_W  instruction from icache.
- ihit  in  1  instruction request complete.
- dhit  in  1  data request complete.
- zero  in  1  ALU zero flag, valid in EXEC.
- link_inval  in  1  external invalidate of the LL link (coherence/snoop).
- iREN  out  1  instruction read request.
- irWEN  out  1  instruction register latch strobe.
- pcWEN  out  1  PC update strobe.
- dREN, dWEN  out  1 each  data read/write request.
- datomic  out  1  marks LL/SC data access.
- WEN  out  1  register file write enable.
- wsel  out  5  destination register.
- alusrc, wdatsel, aluop, pc_select  out  pkg types  datapath controls, same encodings as cpu_types_pkg.
- immediate, lui_word  out  WORD_W  sign-extended / upper immediate.
- sc_success  out  1  SC outcome, written as rt data in SC WB.
- mem_err  out  1  sticky; timeout occurred.
- cpu_halt  out  1  sticky halt.

## Operation

- **States:** RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **RESET**
  - All outputs are 0; link is 0; the wait counter is 0.
  - The first rising edge with nRST high moves the FSM to FETCH.
- **FETCH**
  - iREN=1.
  - On ihit: irWEN=1 in the same cycle, then move to DECODE.
- **DECODE**
  - Opcode/funct are decoded from the latched IR.
  - HALT opcode (0x3F): move to HALT.
  - Otherwise: move to EXEC.
- **EXEC**
  - ALU controls are valid.
  - Branch/jump instructions: pcWEN=1 with pc_select (branch taken per zero/BEQ/BNE), then move to FETCH.
  - LW/SW/LL/SC: move to MEM.
  - All others: move to WB.
- **MEM**
  - LW/LL: dREN=1.
  - SW, and SC with link=1: dWEN=1.
  - datomic=1 for LL/SC.
  - Leave on dhit: LW/LL/SC go to WB; SW pulses pcWEN and goes to FETCH.
  - SC with link=0: no request is issued; go to WB in the next cycle.
- **WB**
  - WEN=1 and pcWEN=1 (PC+4 or JAL per pc_select), then move to FETCH.
  - wsel is rd for R-type, rt for I-type, 31 for JAL.
- **HALT**
  - cpu_halt=1; all requests 0.
  - The FSM stays in HALT until reset.
- **Link flag**
  - Set when an LL dhit is taken.
  - Cleared by link_inval, by any SC completing (success or fail), or by reset.
  - If link_inval and an LL dhit occur in the same cycle, the set wins (the invalidate precedes the load).
  - sc_success = link sampled on MEM entry; it is held through WB.
- **Timeout** (TIMEOUT>0)
  - The wait counter increments each FETCH/MEM cycle without a hit and clears on a hit or state change.
  - When the counter reaches TIMEOUT: set mem_err and move to HALT next cycle.
  - A hit in the same cycle the counter reaches TIMEOUT is honoured and does not set mem_err.
- **Reset mid-operation:** nRST low forces RESET immediately (asynchronously); all strobes drop in the same cycle.

## Timing

- **Cycles per instruction** (zero-wait hits):
  - R-type/I-type ALU: 4.
  - LW/LL/SC: 5.
  - SW: 4.
  - Branch/jump: 3.
  - Each wait cycle on ihit/dhit adds 1.
- **Strobe widths:** irWEN, pcWEN and WEN are single-cycle pulses, at most one of each per instruction.
- **Request lines:** iREN/dREN/dWEN stay high continuously until the hit cycle inclusive and drop in the following cycle.
- **Control outputs:** immediate, lui_word, wsel, aluop, alusrc and wdatsel are decoded from the IR and are stable from DECODE through the end of the instruction.

## Test plan

- **Reset, then ADDU.** Reset, then release with imemload=0x00221821 (ADDU $3,$1,$2) and ihit after 2 wait cycles.
  - FETCH lasts 3 cycles; irWEN pulses once.
  - WEN=1 with wsel=3 occurs exactly 6 cycles after leaving RESET.
- **LW.** 0x8C220004 (LW $2,4($1)) with dhit after 1 wait cycle.
  - dREN is high for 2 cycles.
  - immediate=0x00000004, WEN with wsel=2, total 6 cycles.
- **LL/SC, link intact.** LL 0xC0850000 then SC 0xE0850000 with no invalidate.
  - Both accesses show datomic=1; SC shows dWEN=1 and sc_success=1.
  - Replay with link_inval pulsed between them: the SC shows no dWEN, sc_success=0, WEN=1 with wsel=5.
- **BEQ.** 0x10220003 (BEQ $1,$2,+3) with zero=1, then zero=0.
  - pcWEN pulses in EXEC with taken/untaken pc_select; 3 cycles; no WEN.
- **Timeout.** TIMEOUT=4 with ihit held low.
  - mem_err=1 and cpu_halt=1 after 4 FETCH cycles.
  - Repeat with ihit on the 4th cycle: the fetch completes and mem_err stays 0.
- **HALT.** 0xFFFFFFFF decoded.
  - cpu_halt=1 from the cycle after DECODE; no further iREN.
  - Asserting nRST clears cpu_halt immediately.
